// File: rtl/counter_seq_ctrl_if.sv
// Command/config handshake and status bundle for counter_seq_ctrl.
// The master drives commands and config; the slave (the controller) returns status.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cfg_load;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_dir;
  logic             cfg_reload;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             tc;
  logic             done;
  logic             cmd_err;
  logic [1:0]       state;

  modport master (
    output cmd_valid, cmd_op, cfg_load, cfg_limit, cfg_dir, cfg_reload,
    input  cmd_ready, out, busy, tc, done, cmd_err, state
  );

  modport slave (
    input  cmd_valid, cmd_op, cfg_load, cfg_limit, cfg_dir, cfg_reload,
    output cmd_ready, out, busy, tc, done, cmd_err, state
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Up/down counter sequencer: START/PAUSE/ABORT commands over valid/ready, one-shot or auto-reload.
// Count is registered; START at edge k shows the load value after edge k. Commands are refused only in DONE.
module counter_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  counter_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             dir_q, dir_d;
  logic             reload_q, reload_d;
  logic             err_q, err_d;
  logic             cmd_ready;
  logic             accept;

  assign cmd_ready = (state_q != DONE);
  assign accept    = bus.cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      load_q   <= '0;
      lim_q    <= '0;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      lim_q    <= lim_d;
      dir_q    <= dir_d;
      reload_q <= reload_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    lim_d    = lim_q;
    dir_d    = dir_q;
    reload_d = reload_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_START: begin
              cnt_d    = bus.cfg_load;
              load_d   = bus.cfg_load;
              lim_d    = bus.cfg_limit;
              dir_d    = bus.cfg_dir;
              reload_d = bus.cfg_reload;
              state_d  = RUN;
            end
            OP_PAUSE: err_d = 1'b1;
            default:  ;
          endcase
        end
      end

      RUN: begin
        // ABORT and PAUSE pre-empt the terminal action; a paused terminal is re-checked on resume.
        if (accept && bus.cmd_op == OP_ABORT) begin
          state_d = IDLE;
        end else if (accept && bus.cmd_op == OP_PAUSE) begin
          state_d = PAUSE;
        end else begin
          if (accept && bus.cmd_op == OP_START) begin
            err_d = 1'b1;
          end
          if (cnt_q == lim_q) begin
            if (reload_q) begin
              cnt_d = load_q;
            end else begin
              state_d = DONE;
            end
          end else if (dir_q) begin
            cnt_d = cnt_q - WIDTH'(1);
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end

      PAUSE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_PAUSE: state_d = RUN;
            OP_ABORT: state_d = IDLE;
            OP_START: err_d   = 1'b1;
            default:  ;
          endcase
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.out       = cnt_q;
  assign bus.busy      = (state_q == RUN) || (state_q == PAUSE);
  assign bus.tc        = (state_q == RUN) && (cnt_q == lim_q);
  assign bus.done      = (state_q == DONE);
  assign bus.cmd_err   = err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: hand-computed count sequences, pause/abort/error cases, async reset.
module tb_counter_seq_ctrl;

  logic clk;
  logic rstn;
  int   compared;
  int   mismatched;

  counter_seq_ctrl_if #(.WIDTH(4)) bus ();

  counter_seq_ctrl #(.WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
  endtask

  task automatic set_cfg(input logic [3:0] ld, input logic [3:0] lim, input logic dir, input logic rel);
    bus.cfg_load   = ld;
    bus.cfg_limit  = lim;
    bus.cfg_dir    = dir;
    bus.cfg_reload = rel;
  endtask

  initial begin
    logic [3:0] seq2 [4];
    logic [3:0] seq3 [7];
    logic [3:0] v;
    compared   = 0;
    mismatched = 0;
    seq2 = '{4'd1, 4'd0, 4'd15, 4'd14};
    seq3 = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd13, 4'd14, 4'd15};

    rstn          = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    set_cfg(4'd0, 4'd0, 1'b0, 1'b0);
    #100;
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.cmd_err), 0);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    chk("rst_done", 32'(bus.done), 0);
    rstn = 1'b0;
    tick();

    // 1: up one-shot 3..7
    set_cfg(4'd3, 4'd7, 1'b0, 1'b0);
    cmd(2'b01);
    chk("t1_out3", 32'(bus.out), 3);
    chk("t1_state_run", 32'(bus.state), 1);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_tc3", 32'(bus.tc), 0);
    for (int i = 4; i <= 7; i++) begin
      tick();
      chk("t1_out", 32'(bus.out), 32'(i));
      chk("t1_tc", 32'(bus.tc), (i == 7) ? 1 : 0);
      chk("t1_done_lo", 32'(bus.done), 0);
    end
    tick();
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_state_done", 32'(bus.state), 3);
    chk("t1_out_done", 32'(bus.out), 7);
    chk("t1_ready_done", 32'(bus.cmd_ready), 0);
    tick();
    chk("t1_done_end", 32'(bus.done), 0);
    chk("t1_idle", 32'(bus.state), 0);
    chk("t1_out_idle", 32'(bus.out), 7);
    chk("t1_busy_idle", 32'(bus.busy), 0);

    // 2: down one-shot 2 -> 14 with wrap; config changes mid-run must be ignored
    set_cfg(4'd2, 4'd14, 1'b1, 1'b0);
    cmd(2'b01);
    chk("t2_out2", 32'(bus.out), 2);
    set_cfg(4'd9, 4'd9, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      v = seq2[i];
      chk("t2_out", 32'(bus.out), 32'(v));
      chk("t2_done_lo", 32'(bus.done), 0);
    end
    chk("t2_tc14", 32'(bus.tc), 1);
    tick();
    chk("t2_done", 32'(bus.done), 1);
    chk("t2_out_done", 32'(bus.out), 14);
    tick();
    chk("t2_idle", 32'(bus.state), 0);

    // 3: up reload 13 -> 1, abort at 15
    set_cfg(4'd13, 4'd1, 1'b0, 1'b1);
    cmd(2'b01);
    chk("t3_out13", 32'(bus.out), 13);
    for (int i = 0; i < 7; i++) begin
      tick();
      v = seq3[i];
      chk("t3_out", 32'(bus.out), 32'(v));
      chk("t3_tc", 32'(bus.tc), (v == 4'd1) ? 1 : 0);
      chk("t3_no_done", 32'(bus.done), 0);
      chk("t3_state", 32'(bus.state), 1);
    end
    cmd(2'b11);
    chk("t3_abort_state", 32'(bus.state), 0);
    chk("t3_abort_out", 32'(bus.out), 15);
    chk("t3_abort_done", 32'(bus.done), 0);
    tick();
    chk("t3_abort_done2", 32'(bus.done), 0);

    // 4a: pause at 5, resume, finish at 9
    set_cfg(4'd2, 4'd9, 1'b0, 1'b0);
    cmd(2'b01);
    tick(); tick(); tick();
    chk("t4_out5", 32'(bus.out), 5);
    cmd(2'b10);
    chk("t4_paused", 32'(bus.state), 2);
    chk("t4_hold0", 32'(bus.out), 5);
    chk("t4_busy_p", 32'(bus.busy), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_hold", 32'(bus.out), 5);
      chk("t4_tc_p", 32'(bus.tc), 0);
      chk("t4_state_p", 32'(bus.state), 2);
    end
    cmd(2'b10);
    chk("t4_resumed", 32'(bus.state), 1);
    chk("t4_resume_out", 32'(bus.out), 5);
    for (int i = 6; i <= 9; i++) begin
      tick();
      chk("t4_out", 32'(bus.out), 32'(i));
    end
    tick();
    chk("t4_done", 32'(bus.done), 1);
    tick();
    chk("t4_idle", 32'(bus.state), 0);

    // 4b: pause exactly when out==lim defers DONE
    set_cfg(4'd7, 4'd8, 1'b0, 1'b0);
    cmd(2'b01);
    tick();
    chk("t4b_tc", 32'(bus.tc), 1);
    cmd(2'b10);
    chk("t4b_paused", 32'(bus.state), 2);
    chk("t4b_nodone", 32'(bus.done), 0);
    chk("t4b_tc_p", 32'(bus.tc), 0);
    tick();
    chk("t4b_still_p", 32'(bus.state), 2);
    cmd(2'b10);
    chk("t4b_run", 32'(bus.state), 1);
    chk("t4b_out", 32'(bus.out), 8);
    tick();
    chk("t4b_done", 32'(bus.done), 1);
    tick();
    chk("t4b_idle", 32'(bus.state), 0);

    // 5: illegal commands and DONE backpressure
    cmd(2'b10);
    chk("t5_idle_err", 32'(bus.cmd_err), 1);
    chk("t5_idle_state", 32'(bus.state), 0);
    tick();
    chk("t5_err_clr", 32'(bus.cmd_err), 0);
    set_cfg(4'd0, 4'd3, 1'b0, 1'b0);
    cmd(2'b01);
    tick();
    chk("t5_out1", 32'(bus.out), 1);
    set_cfg(4'd9, 4'd12, 1'b1, 1'b1);
    cmd(2'b01);
    chk("t5_run_err", 32'(bus.cmd_err), 1);
    chk("t5_out2", 32'(bus.out), 2);
    tick();
    chk("t5_out3", 32'(bus.out), 3);
    chk("t5_err_clr2", 32'(bus.cmd_err), 0);
    set_cfg(4'd5, 4'd6, 1'b0, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    tick();
    chk("t5_done", 32'(bus.done), 1);
    chk("t5_ready_lo", 32'(bus.cmd_ready), 0);
    tick();
    chk("t5_idle", 32'(bus.state), 0);
    chk("t5_ready_hi", 32'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    chk("t5_accepted", 32'(bus.state), 1);
    chk("t5_out5", 32'(bus.out), 5);
    tick();
    chk("t5_out6", 32'(bus.out), 6);
    tick();
    chk("t5_done2", 32'(bus.done), 1);
    tick();

    // 6: async reset mid-run
    set_cfg(4'd3, 4'd9, 1'b0, 1'b0);
    cmd(2'b01);
    tick(); tick(); tick();
    chk("t6_out6", 32'(bus.out), 6);
    #3;
    rstn = 1'b1;
    #1;
    chk("t6_async_out", 32'(bus.out), 0);
    chk("t6_async_state", 32'(bus.state), 0);
    chk("t6_async_busy", 32'(bus.busy), 0);
    tick();
    chk("t6_no_done", 32'(bus.done), 0);
    rstn = 1'b0;
    tick();
    set_cfg(4'd3, 4'd7, 1'b0, 1'b0);
    cmd(2'b01);
    chk("t6_out3", 32'(bus.out), 3);
    for (int i = 4; i <= 7; i++) begin
      tick();
      chk("t6_out", 32'(bus.out), 32'(i));
    end
    tick();
    chk("t6_done", 32'(bus.done), 1);
    tick();
    chk("t6_idle", 32'(bus.state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Controller that sequences a WIDTH-bit up/down counter datapath. The counter supports a programmable load value, a terminal limit, direction, and one-shot or auto-reload mode. Software or an upstream FSM issues START/PAUSE/ABORT commands over a valid/ready handshake. The block reports the count, terminal-count, done and error status to the rest of the design.

Parameters:
WIDTH, 4, counter and config bit width.

Ports:
clk  in  1  single system clock, rising edge.
rstn  in  1  asynchronous, active-high reset (port name fixed as rstn; asserted = 1).
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge.
cmd_op  in  2  00 NOP, 01 START, 10 PAUSE/RESUME toggle, 11 ABORT.
cfg_load  in  WIDTH  start value, sampled on accepted START.
cfg_limit  in  WIDTH  terminal value, sampled on accepted START.
cfg_dir  in  1  0 = count up, 1 = count down; sampled on START.
cfg_reload  in  1  1 = auto-reload at terminal, 0 = one-shot; sampled on START.
out  out  WIDTH  current count (registered).
busy  out  1  state is RUN or PAUSE.
tc  out  1  terminal count flag, combinational = (state==RUN && out==lim_q).
done  out  1  one-cycle pulse, high while state==DONE.
cmd_err  out  1  registered one-cycle pulse, cycle after an illegal command is accepted.
state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (rstn=1, async): state=IDLE, out=0, latched load/lim/dir/reload=0, cmd_err=0. Reset mid-count aborts immediately with no done pulse.
- cmd_ready = 1 in IDLE/RUN/PAUSE, 0 in DONE. A NOP is accepted with no effect.
- IDLE:
  - START → out<=cfg_load, latch config, state<=RUN.
  - PAUSE → cmd_err; state stays IDLE.
  - ABORT → no-op.
- RUN, evaluated each edge, where "command" means an accepted command:
  - ABORT → IDLE, out holds. ABORT has priority over the terminal action.
  - PAUSE → PAUSE, out holds, no step. The terminal action is deferred and re-evaluated after resume.
  - START → cmd_err, then continue as if NOP.
  - Otherwise, if out==lim_q:
    - reload=1 → out<=load_q, stay RUN.
    - reload=0 → state<=DONE, out holds lim_q.
  - Otherwise → out<=out+1 (dir=0) or out-1 (dir=1), modulo 2^WIDTH (wrap 15→0 up, 0→15 down).
- PAUSE:
  - PAUSE → RUN; counting resumes on the following edge.
  - ABORT → IDLE.
  - START → cmd_err.
  - Hold out; tc=0.
- DONE: lasts exactly one cycle, then IDLE. out holds. Commands are not accepted.
- Latency: START accepted at edge k gives out=load after k and out=load±n after edge k+n.
- RUN cycles in one-shot mode = ((lim−load) mod 2^W)+1 for up, or ((load−lim) mod 2^W)+1 for down.
- load==lim: tc is high in the first RUN cycle. One-shot goes to DONE at the next edge; reload holds out=load with tc high every cycle.
- Config inputs are ignored except on an accepted START. Changing them mid-run has no effect.
- busy = (state==RUN || state==PAUSE).

Test Plan:
1. Reset 100 ns, then START load=3 lim=7 up one-shot → out 3,4,5,6,7 on consecutive cycles; tc=1 only at 7; done pulses one cycle; then IDLE with out=7; busy low.
2. START load=2 lim=14 down one-shot → out 2,1,0,15,14 (wrap); done after 5 RUN cycles.
3. START load=13 lim=1 up reload → out 13,14,15,0,1,13,14,…; tc high at each 1; no done; ABORT at out=15 → IDLE, out=15, no done.
4. Running at out=5 (lim=9): PAUSE → out holds 5 for 3 cycles with tc=0; PAUSE again → out 6 on the next edge; reaches 9 then DONE. Also: PAUSE issued in the cycle out==lim → no DONE until resumed.
5. PAUSE in IDLE → cmd_err=1 one cycle, state stays 0. START while RUN → cmd_err=1, count unaffected. cmd_ready=0 during DONE, and a START held valid is accepted the next cycle.
6. Assert rstn mid-run at out=6 → out=0 and state=IDLE asynchronously (before the next clk edge); no done pulse; the next START behaves as in case 1.
